adc_responder: RTL and testbench
================================

Name: adc_responder

Overview:
- Behavioural and synthesizable model of the 8-bit ADC that sits on the far end of the transient-capture block's ADC interface.
- Answers the capture block's `req`/`rst` with `rdy`/`dat` using a four-phase handshake.
- Serves samples from an internal loadable waveform table, with a programmable conversion latency.
- Used as the stimulus source in capture-path benches and as the FPGA stand-in when no physical ADC is fitted.

Parameters:
- DATA_W, 8: sample width; matches `dat`.
- DEPTH, 64: waveform table entries; must be a power of two.
- ADDR_W, 6: log2(DEPTH).
- LATENCY, 3: cycles from `req` sampled high to `rdy` asserted; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  conversion request from capture block (level, four-phase).
- rst  in  1  ADC soft reset from capture block; synchronous, active-high.
- rdy  out  1  sample valid; held until `req` falls.
- dat  out  DATA_W  sample value; stable while `rdy`=1.
- ld_en  in  1  table write strobe.
- ld_addr  in  ADDR_W  table write address.
- ld_dat  in  DATA_W  table write data.
- idx  out  ADDR_W  table index of the next sample to be served.
- wrap  out  1  one-cycle pulse when `idx` wraps from DEPTH-1 to 0.
- busy  out  1  high in CONV and DONE.

Behaviour:
- Reset (async, `reset`=1):
  - state=IDLE; `rdy`=0, `dat`=0, `idx`=0, `wrap`=0, `busy`=0, latency counter=0.
  - Table contents are not cleared.
- FSM states:
  - IDLE: `rdy`=0. On an edge with `req`=1: go to CONV, load counter with LATENCY-1.
  - CONV: `busy`=1. Counter decrements each edge.
    - If `req`=0 at any edge: abort to IDLE; no `rdy`, `idx` unchanged.
    - At the edge where counter==0 and `req`=1: go to DONE, set `rdy`=1, latch `dat`=table[`idx`].
    - Result: `rdy` is first visible LATENCY edges after the edge that sampled `req` high.
  - DONE: `rdy`=1, `dat` held.
    - On an edge with `req`=0: `rdy`=0, `idx`=`idx`+1 mod DEPTH, go to IDLE.
    - `dat` keeps its last value after `rdy` falls.
- Back-to-back requests: `req` re-sampled high on the edge after the return to IDLE starts the next conversion. Minimum spacing between `rdy` rising edges is LATENCY+2 cycles.
- `wrap`: pulses for exactly one cycle on the edge where `idx` goes DEPTH-1 -> 0.
- Soft reset (`rst`=1, synchronous):
  - Highest priority after `reset`.
  - Next edge: state=IDLE, `rdy`=0, `idx`=0, `wrap`=0, counter=0; `dat` holds its value.
  - `req` is ignored while `rst`=1.
  - A `rst` during DONE does not increment `idx`.
- Table load:
  - `ld_en`=1 writes `ld_dat` to table[`ld_addr`] at the edge; legal in any state.
  - If a write and the DONE-entry latch hit the same address on the same edge, `dat` takes the old value.
- Mid-operation `reset`: outputs go to reset values immediately, without waiting for a clock edge.
- Widths:
  - `idx` arithmetic is modulo DEPTH; no saturation.
  - Counter is 4 bits.

Test Plan:
- Reset and idle:
  - Stimulus: assert `reset` mid-CONV.
  - Required: `rdy`, `busy`, `idx` go to 0 asynchronously; after release, state IDLE with `req`=0 held for 10 cycles, `rdy` stays 0.
- Single handshake (LATENCY=3):
  - Stimulus: load table[0]=8'hD6; raise `req` at edge 0.
  - Required: `rdy`=1 and `dat`=8'hD6 from edge 3; after `req` drops, `rdy`=0 next edge and `idx`=1.
- Aborted conversion:
  - Stimulus: `req` high for 2 cycles, then low.
  - Required: `rdy` never asserts; `idx` stays 0; `busy` returns to 0.
- Burst and wrap (DEPTH=64):
  - Stimulus: load table[i]=i; run 65 back-to-back handshakes.
  - Required: `dat` sequence is 0..63 then 0; `wrap` pulses once, after the 64th handshake; `rdy` rising edges are 5 cycles apart.
- Soft reset:
  - Stimulus: after 10 samples, pulse `rst` while in DONE.
  - Required: `rdy`=0, `idx`=0 next edge, no increment; `req` held high during `rst` is ignored; next request returns table[0].
- Load collision:
  - Stimulus: table[2]=8'h11; write 8'h22 to address 2 on the same edge as DONE entry for `idx`=2.
  - Required: `dat`=8'h11; on the next wrap pass, address 2 returns 8'h22.

Source files
------------

// File: rtl/adc_responder_if.sv
// adc_responder_if
// Handshake bundle between the transient-capture block (master) and the
// ADC responder (slave).
//   req : conversion request, level, four-phase      (master -> slave)
//   rst : ADC soft reset, synchronous, active-high    (master -> slave)
//   rdy : sample valid, held until req falls          (slave -> master)
//   dat : sample value, stable while rdy is high      (slave -> master)
interface adc_responder_if #(
  parameter int DATA_W = 8
) ();
  logic              req;
  logic              rst;
  logic              rdy;
  logic [DATA_W-1:0] dat;

  modport master (output req, output rst, input rdy, input dat);
  modport slave  (input req, input rst, output rdy, output dat);
endinterface

// File: rtl/adc_responder.sv
// adc_responder
// Stand-in for the 8-bit ADC behind the capture block. Each four-phase
// request is answered LATENCY edges later with the next entry of a loadable
// waveform table; the table index advances when the request is released.
// Ports:
//   clk     : system clock, rising edge
//   reset   : asynchronous active-high reset (table contents survive it)
//   adc     : handshake bundle (req/rst in, rdy/dat out)
//   ld_en   : table write strobe
//   ld_addr : table write address
//   ld_dat  : table write data
//   idx     : table index of the next sample to be served
//   wrap    : one-cycle pulse when idx rolls over from DEPTH-1 to 0
//   busy    : high while converting or holding a sample
module adc_responder #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  adc_responder_if.slave    adc,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_dat,
  output logic [ADDR_W-1:0] idx,
  output logic              wrap,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam logic [3:0]        LAT_M1 = 4'(LATENCY - 1);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nx;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nx;
  logic [ADDR_W-1:0] idx_nx;
  logic              wrap_nx;
  logic              latch;
  logic [DATA_W-1:0] dat_q;
  logic [DATA_W-1:0] table_mem [DEPTH];

  // Next-state and datapath decisions. Soft reset overrides everything and
  // deliberately leaves dat alone; a request that drops during conversion
  // aborts without touching idx.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    wrap_nx  = 1'b0;
    latch    = 1'b0;
    if (adc.rst) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (adc.req) begin
            state_nx = CONV;
            cnt_nx   = LAT_M1;
          end
        end
        CONV: begin
          if (!adc.req) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (cnt == 4'd0) begin
            state_nx = DONE;
            latch    = 1'b1;
          end else begin
            cnt_nx = cnt - 4'd1;
          end
        end
        DONE: begin
          if (!adc.req) begin
            state_nx = IDLE;
            idx_nx   = idx + ADDR_W'(1);
            wrap_nx  = (idx == LAST);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Counter, index, wrap pulse and output sample. The sample is read from the
  // table with the pre-edge contents, so a same-edge write to the same
  // address is not seen until the next pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      idx   <= '0;
      wrap  <= 1'b0;
      dat_q <= '0;
    end else begin
      cnt  <= cnt_nx;
      idx  <= idx_nx;
      wrap <= wrap_nx;
      if (latch) dat_q <= table_mem[idx];
    end
  end

  // Waveform table; never reset so a loaded pattern survives both resets.
  always_ff @(posedge clk) begin
    if (ld_en) table_mem[ld_addr] <= ld_dat;
  end

  assign adc.rdy = (state == DONE);
  assign adc.dat = dat_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_adc_responder.sv
// tb_adc_responder
// Drives the ADC responder as the capture block would, plus a random phase,
// and compares every cycle against a conversion-progress model of the ADC.
module tb_adc_responder;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int LAT    = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_dat;
  logic [ADDR_W-1:0] idx;
  logic              wrap;
  logic              busy;

  adc_responder_if #(.DATA_W(DATA_W)) bus ();

  adc_responder #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .adc(bus),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_dat(ld_dat),
    .idx(idx), .wrap(wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cycle = 0;
  int hsCount = 0;
  int wrapSeen = 0;
  int wrapAtHs = -1;
  int lastLatency = 0;
  bit cmpOn = 1'b0;

  // Model: a conversion is "active" from the edge req is first seen high;
  // held counts further edges with req still high, saturating at LAT.
  logic [DATA_W-1:0] mTable [DEPTH];
  bit                mActive;
  int                mHeld;
  logic [ADDR_W-1:0] mIdx;
  logic [DATA_W-1:0] mDat;
  bit                mWrap;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
  endtask

  always @(posedge clk) cycle++;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mActive = 1'b0; mHeld = 0; mIdx = '0; mDat = '0; mWrap = 1'b0;
    end else begin
      mWrap = 1'b0;
      if (bus.rst) begin
        mActive = 1'b0; mHeld = 0; mIdx = '0;
      end else if (!mActive) begin
        if (bus.req) begin mActive = 1'b1; mHeld = 0; end
      end else if (bus.req) begin
        if (mHeld < LAT) begin
          mHeld++;
          if (mHeld == LAT) mDat = mTable[mIdx];
        end
      end else begin
        if (mHeld == LAT) begin
          mWrap = (mIdx == ADDR_W'(DEPTH - 1));
          mIdx  = mIdx + ADDR_W'(1);
        end
        mActive = 1'b0; mHeld = 0;
      end
      if (ld_en) mTable[ld_addr] = ld_dat;
    end
  end

  always @(negedge clk) begin
    if (!reset && cmpOn) begin
      checkOutput("rdy",  32'(bus.rdy), 32'(mActive && mHeld == LAT));
      checkOutput("busy", 32'(busy),    32'(mActive));
      checkOutput("idx",  32'(idx),     32'(mIdx));
      checkOutput("wrap", 32'(wrap),    32'(mWrap));
      checkOutput("dat",  32'(bus.dat), 32'(mDat));
      if (wrap === 1'b1) begin wrapSeen++; wrapAtHs = hsCount; end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic r, input logic s, input logic le,
                               input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] lv);
    bus.req = r; bus.rst = s; ld_en = le; ld_addr = la; ld_dat = lv;
    @(posedge clk);
    #2;
  endtask

  // Raise req until rdy, then return with req dropped for exactly one edge.
  task automatic handshake(output logic [DATA_W-1:0] got, output int riseCycle);
    int n;
    n = 0;
    do begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
      n++;
    end while (bus.rdy !== 1'b1 && n < 20);
    if (bus.rdy !== 1'b1) checkOutput("hs_timeout", 32'd0, 32'd1);
    got = bus.dat;
    riseCycle = cycle;
    lastLatency = n - 1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    hsCount++;
  endtask

  initial begin
    logic [DATA_W-1:0] got;
    int rc, prevRc, badGap, n;
    reset = 1'b1;
    bus.req = 1'b0; bus.rst = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_dat = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    cmpOn = 1'b1;
    checkOutput("reset_rdy",  32'(bus.rdy), 32'd0);
    checkOutput("reset_busy", 32'(busy),    32'd0);
    checkOutput("reset_idx",  32'(idx),     32'd0);
    checkOutput("reset_dat",  32'(bus.dat), 32'd0);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("idle_rdy", 32'(bus.rdy), 32'd0);

    $display("[TB] aborted conversion");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    checkOutput("abort_busy_mid", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("abort_busy", 32'(busy),    32'd0);
    checkOutput("abort_rdy",  32'(bus.rdy), 32'd0);
    checkOutput("abort_idx",  32'(idx),     32'd0);

    $display("[TB] table load and single handshake");
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, ADDR_W'(i), DATA_W'(i));
    applyStimulus(1'b0, 1'b0, 1'b1, '0, 8'hD6);
    handshake(got, rc);
    checkOutput("single_dat",     32'(got),         32'hD6);
    checkOutput("single_latency", 32'(lastLatency), 32'd3);
    checkOutput("single_rdy_low", 32'(bus.rdy),     32'd0);
    checkOutput("single_idx",     32'(idx),         32'd1);

    $display("[TB] burst and wrap");
    applyStimulus(1'b0, 1'b0, 1'b1, '0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
    hsCount = 0; wrapSeen = 0; badGap = 0; prevRc = 0;
    for (int k = 0; k < 65; k++) begin
      handshake(got, rc);
      checkOutput("burst_dat", 32'(got), 32'(k % 64));
      if (k > 0 && rc - prevRc != 5) badGap++;
      prevRc = rc;
    end
    checkOutput("burst_gap_errors", 32'(badGap),   32'd0);
    checkOutput("wrap_count",       32'(wrapSeen), 32'd1);
    checkOutput("wrap_after_hs",    32'(wrapAtHs), 32'd64);

    $display("[TB] soft reset in DONE");
    repeat (9) handshake(got, rc);
    checkOutput("pre_srst_idx", 32'(idx), 32'd10);
    n = 0;
    do begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
      n++;
    end while (bus.rdy !== 1'b1 && n < 20);
    checkOutput("srst_in_done", 32'(bus.rdy), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, '0, '0);
    checkOutput("srst_rdy",  32'(bus.rdy), 32'd0);
    checkOutput("srst_idx",  32'(idx),     32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0, '0);
    checkOutput("srst_req_ignored", 32'(busy), 32'd0);
    handshake(got, rc);
    checkOutput("srst_next_dat",     32'(got),         32'h00);
    checkOutput("srst_next_latency", 32'(lastLatency), 32'd3);

    $display("[TB] load collision");
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd2, 8'h11);
    handshake(got, rc);
    checkOutput("coll_pre_idx", 32'(idx), 32'd2);
    repeat (LAT) applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'd2, 8'h22);
    checkOutput("coll_rdy", 32'(bus.rdy), 32'd1);
    checkOutput("coll_dat", 32'(bus.dat), 32'h11);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (63) handshake(got, rc);
    handshake(got, rc);
    checkOutput("coll_next_pass", 32'(got), 32'h22);

    $display("[TB] random phase");
    for (int c = 0; c < 1500; c++)
      applyStimulus($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 20, ADDR_W'($urandom), DATA_W'($urandom));

    $display("[TB] async reset mid-conversion");
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) handshake(got, rc);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    checkOutput("midconv_busy", 32'(busy), 32'd1);
    checkOutput("midconv_idx",  32'(idx),  32'd2);
    #1 reset = 1'b1;
    #1;
    checkOutput("async_rdy",  32'(bus.rdy), 32'd0);
    checkOutput("async_busy", 32'(busy),    32'd0);
    checkOutput("async_idx",  32'(idx),     32'd0);
    bus.req = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("post_reset_rdy",  32'(bus.rdy), 32'd0);
    checkOutput("post_reset_busy", 32'(busy),    32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
